branch_stack: RTL and testbench
===============================

Name: branch_stack

Overview:
- Branch-tag and checkpoint manager that feeds dispatch.
- Owns DEPTH branch checkpoints. Hands one one-hot tag per cycle to the branch dispatched in slot 0, and supplies the outstanding-branch mask used to tag every dispatched instruction.
- Frees tags on correct resolution. On mispredict, frees the tag plus all younger tags and replays the stored checkpoint.
- Drives bs_full into dispatch.

Parameters:
DEPTH, 4, number of branch checkpoints / tag bits (>=2)
CP_W, 64, width of opaque checkpoint payload (map-table ptr, freelist head, ROB tail packed by caller)

Ports:
clock  in  1  system clock
reset  in  1  asynchronous, active-high reset
alloc_valid  in  1  dispatch presents a branch in slot 0 this cycle
alloc_cp  in  CP_W  checkpoint snapshot for that branch
alloc_ok  out  1  allocation accepted this cycle (comb)
alloc_tag  out  DEPTH  one-hot tag for the allocating branch; 0 if none free (comb)
cur_mask  out  DEPTH  outstanding tags as of cycle start (registered state)
bs_full  out  1  no free entry (registered state, no same-cycle bypass)
free_cnt  out  $clog2(DEPTH+1)  number of free entries
resolve_valid  in  1  a branch resolves this cycle
resolve_tag  in  DEPTH  one-hot tag of resolving branch
resolve_mispred  in  1  resolving branch mispredicted
clear_valid  out  1  registered pulse: clear_mask bits are freed, correct path
clear_mask  out  DEPTH  tag freed by correct resolve (consumers drop the bit from their masks)
squash_valid  out  1  registered pulse: mispredict recovery
squash_mask  out  DEPTH  tags freed by mispredict (resolved tag plus younger); consumers kill entries carrying any of these bits
restore_cp  out  CP_W  checkpoint of the mispredicted branch, valid with squash_valid

Behaviour:
- State per entry i: vld[i], dep[i][DEPTH-1:0] (older tags outstanding at allocation), cp[i][CP_W-1:0].
- Reset (async): all vld=0, dep=0, cp=0. Outputs: cur_mask=0, bs_full=0, free_cnt=DEPTH, clear_valid=0, clear_mask=0, squash_valid=0, squash_mask=0, restore_cp=0.
- cur_mask = vld. bs_full = &vld. free_cnt = DEPTH - popcount(vld).
- Allocation (comb decision, registered update):
  - alloc_tag = lowest-index entry with vld=0.
  - alloc_ok = alloc_valid & !bs_full & !(resolve_valid & resolve_mispred & vld[resolve_tag]).
  - On alloc_ok: next cycle vld[idx]=1, cp[idx]=alloc_cp, dep[idx] = vld minus the correctly-resolving tag (if any this cycle).
  - Frees in the same cycle do not enable allocation until the next cycle.
- Correct resolve (resolve_valid & !resolve_mispred & tag valid):
  - Next cycle: vld[tag]=0, bit cleared from every dep[].
  - clear_valid=1, clear_mask=resolve_tag for exactly one cycle.
- Mispredict (resolve_valid & resolve_mispred & tag valid):
  - younger = {j : vld[j] & dep[j] has tag}.
  - Next cycle: vld cleared for tag ∪ younger; dep bits for the freed tags cleared in survivors.
  - squash_valid=1, squash_mask = tag|younger, restore_cp = cp[tag] (value before update). One-cycle pulse.
  - Same-cycle alloc is dropped: alloc_ok=0, because that branch is on the wrong path.
- Resolve naming an invalid tag: no state change, no pulses.
- resolve_tag not one-hot while resolve_valid=1 is illegal; flag with an assertion under DEBUG.
- Pulse outputs are 0 in every cycle without a qualifying resolve.
- Only one alloc and one resolve per cycle.
- Latency: alloc is visible in cur_mask/bs_full 1 cycle later. Recovery outputs appear 1 cycle after resolve.
- Reset mid-operation clears everything immediately. Any pending pulse is lost.

Decomposition:
- Shared package/sys_defs gets:
  - `BRANCH_PRED_SZ (DEPTH default)
  - typedef BR_MASK (logic [DEPTH-1:0])
  - typedef BR_CHECKPOINT (packed struct forming alloc_cp/restore_cp)
- One sub-module is natural: psel_lowest (lowest-set-bit one-hot selector on ~vld), reusable by RS/freelist.

Test Plan:
- Reset, then idle -> cur_mask=0, bs_full=0, free_cnt=4, all pulses 0.
- Alloc 4 branches on consecutive cycles (cp=1,2,3,4) -> alloc_tag 0001,0010,0100,1000; after 4th, bs_full=1, free_cnt=0; 5th alloc_valid -> alloc_ok=0.
- Full stack, correct resolve tag 0010 -> next cycle clear_valid=1, clear_mask=0010, cur_mask=1101; dep of tags 0100 and 1000 lose bit 1; next alloc gets 0010.
- Tags 0001..1000 allocated in order, mispredict 0010 -> next cycle squash_valid=1, squash_mask=1110, restore_cp=2, cur_mask=0001, free_cnt=3.
- Mispredict 0001 with alloc_valid=1 in same cycle -> alloc_ok=0; next cycle squash_mask = all outstanding, cur_mask=0.
- Correct resolve 0001 plus alloc in same cycle with cur_mask=0011 -> new entry 0100 gets dep=0010; a later mispredict of 0010 squashes 0100.

Source files
------------

// File: rtl/branch_stack_pkg.sv
// Shared branch-tag definitions: default stack depth, tag mask type and the
// checkpoint payload that dispatch snapshots per branch.
package branch_stack_pkg;

  localparam int BRANCH_PRED_SZ = 4;

  typedef logic [BRANCH_PRED_SZ-1:0] BR_MASK;

  typedef struct packed {
    logic [15:0] map_ptr;
    logic [23:0] fl_head;
    logic [23:0] rob_tail;
  } BR_CHECKPOINT;

  localparam int BR_CP_W = $bits(BR_CHECKPOINT);

endpackage

// File: rtl/branch_stack_if.sv
// Dispatch/resolve bundle of the branch stack; master is the pipeline side,
// slave is the branch stack itself.
interface branch_stack_if
  import branch_stack_pkg::*;
#(
  parameter int DEPTH = BRANCH_PRED_SZ,
  parameter int CP_W  = BR_CP_W
);
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic             alloc_valid;
  logic [CP_W-1:0]  alloc_cp;
  logic             alloc_ok;
  logic [DEPTH-1:0] alloc_tag;
  logic [DEPTH-1:0] cur_mask;
  logic             bs_full;
  logic [CNT_W-1:0] free_cnt;
  logic             resolve_valid;
  logic [DEPTH-1:0] resolve_tag;
  logic             resolve_mispred;
  logic             clear_valid;
  logic [DEPTH-1:0] clear_mask;
  logic             squash_valid;
  logic [DEPTH-1:0] squash_mask;
  logic [CP_W-1:0]  restore_cp;

  modport master (
    output alloc_valid, alloc_cp, resolve_valid, resolve_tag, resolve_mispred,
    input  alloc_ok, alloc_tag, cur_mask, bs_full, free_cnt,
           clear_valid, clear_mask, squash_valid, squash_mask, restore_cp
  );

  modport slave (
    input  alloc_valid, alloc_cp, resolve_valid, resolve_tag, resolve_mispred,
    output alloc_ok, alloc_tag, cur_mask, bs_full, free_cnt,
           clear_valid, clear_mask, squash_valid, squash_mask, restore_cp
  );

endinterface

// File: rtl/branch_stack_psel_lowest.sv
// One-hot select of the lowest set request bit; zero when nothing requests.
module psel_lowest #(
  parameter int W = 4
) (
  input  logic [W-1:0] req,
  output logic [W-1:0] gnt
);

  // Two's complement isolates the lowest set bit.
  assign gnt = req & (~req + W'(1));

endmodule

// File: rtl/branch_stack.sv
// Branch tag / checkpoint stack: allocates one-hot tags to dispatched branches,
// frees them on resolve and replays the checkpoint on mispredict.
module branch_stack
  import branch_stack_pkg::*;
#(
  parameter int DEPTH = BRANCH_PRED_SZ,
  parameter int CP_W  = BR_CP_W
) (
  input logic           clock,
  input logic           reset,
  branch_stack_if.slave bs
);
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [DEPTH-1:0] vld_q, vld_d;
  logic [DEPTH-1:0] dep_q [DEPTH];
  logic [DEPTH-1:0] dep_d [DEPTH];
  logic [CP_W-1:0]  cp_q  [DEPTH];
  logic [CP_W-1:0]  cp_d  [DEPTH];
  logic             clear_valid_q, clear_valid_d;
  logic [DEPTH-1:0] clear_mask_q, clear_mask_d;
  logic             squash_valid_q, squash_valid_d;
  logic [DEPTH-1:0] squash_mask_q, squash_mask_d;
  logic [CP_W-1:0]  restore_cp_q, restore_cp_d;

  logic [DEPTH-1:0] free_tag;
  logic [DEPTH-1:0] res_live;
  logic [DEPTH-1:0] younger;
  logic [DEPTH-1:0] free_mask;
  logic             res_ok;
  logic             res_mis;
  logic             alloc_fire;
  logic [CP_W-1:0]  sel_cp;
  logic [CNT_W-1:0] busy_cnt;

  psel_lowest #(.W(DEPTH)) u_psel (
    .req(~vld_q),
    .gnt(free_tag)
  );

  always_comb begin
    res_live = bs.resolve_valid ? (bs.resolve_tag & vld_q) : '0;
    res_ok   = (|res_live) & ~bs.resolve_mispred;
    res_mis  = (|res_live) & bs.resolve_mispred;
    younger  = '0;
    sel_cp   = '0;
    busy_cnt = '0;
    for (int j = 0; j < DEPTH; j++) begin
      younger[j] = vld_q[j] & (|(dep_q[j] & res_live));
      sel_cp     = sel_cp | (res_live[j] ? cp_q[j] : '0);
      busy_cnt   = busy_cnt + CNT_W'(vld_q[j]);
    end
    free_mask = res_ok ? res_live : (res_mis ? (res_live | younger) : '0);

    // A branch dispatched alongside a mispredict is on the wrong path.
    alloc_fire = bs.alloc_valid & ~(&vld_q) & ~res_mis;
    vld_d      = (vld_q & ~free_mask) | (alloc_fire ? free_tag : '0);

    for (int i = 0; i < DEPTH; i++) begin
      dep_d[i] = dep_q[i] & ~free_mask;
      cp_d[i]  = cp_q[i];
      if (alloc_fire && free_tag[i]) begin
        dep_d[i] = vld_q & ~free_mask;
        cp_d[i]  = bs.alloc_cp;
      end
    end

    clear_valid_d  = res_ok;
    clear_mask_d   = res_ok ? res_live : '0;
    squash_valid_d = res_mis;
    squash_mask_d  = res_mis ? free_mask : '0;
    restore_cp_d   = res_mis ? sel_cp : '0;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      vld_q          <= '0;
      clear_valid_q  <= 1'b0;
      clear_mask_q   <= '0;
      squash_valid_q <= 1'b0;
      squash_mask_q  <= '0;
      restore_cp_q   <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        dep_q[i] <= '0;
        cp_q[i]  <= '0;
      end
    end else begin
      vld_q          <= vld_d;
      clear_valid_q  <= clear_valid_d;
      clear_mask_q   <= clear_mask_d;
      squash_valid_q <= squash_valid_d;
      squash_mask_q  <= squash_mask_d;
      restore_cp_q   <= restore_cp_d;
      for (int i = 0; i < DEPTH; i++) begin
        dep_q[i] <= dep_d[i];
        cp_q[i]  <= cp_d[i];
      end
    end
  end

  assign bs.alloc_ok     = alloc_fire;
  assign bs.alloc_tag    = free_tag;
  assign bs.cur_mask     = vld_q;
  assign bs.bs_full      = &vld_q;
  assign bs.free_cnt     = CNT_W'(DEPTH) - busy_cnt;
  assign bs.clear_valid  = clear_valid_q;
  assign bs.clear_mask   = clear_mask_q;
  assign bs.squash_valid = squash_valid_q;
  assign bs.squash_mask  = squash_mask_q;
  assign bs.restore_cp   = restore_cp_q;

`ifdef DEBUG
  always @(posedge clock) begin
    if (!reset && bs.resolve_valid)
      assert ($onehot(bs.resolve_tag))
      else $error("branch_stack: resolve_tag is not one-hot");
  end
`endif

endmodule

// File: tb/tb_branch_stack.sv
// Bench for branch_stack: directed vector table, an async-reset sequence and
// random traffic checked against an age-ordered list model of the stack.
module tb_branch_stack;
  import branch_stack_pkg::*;

  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  branch_stack_if #(.DEPTH(4), .CP_W(64)) bif ();
  branch_stack #(.DEPTH(4), .CP_W(64)) dut (
    .clock(clock),
    .reset(reset),
    .bs   (bif)
  );

  int n_chk  = 0;
  int n_fail = 0;

  // Model: outstanding entries in allocation order, oldest first.
  int          ord[$];
  logic [63:0] cpm[4];

  typedef struct {
    bit av; logic [63:0] cp; bit rv; BR_MASK rt; bit rm;
    bit ok; BR_MASK tag;
    BR_MASK mask; bit full; int cnt;
    bit cv; BR_MASK cm; bit sv; BR_MASK sm; logic [63:0] rcp;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(bit av, logic [63:0] cp, bit rv, BR_MASK rt, bit rm,
                              bit ok, BR_MASK tag, BR_MASK mask, bit full, int cnt,
                              bit cv, BR_MASK cm, bit sv, BR_MASK sm, logic [63:0] rcp);
    vec_t v;
    v.av = av; v.cp = cp; v.rv = rv; v.rt = rt; v.rm = rm;
    v.ok = ok; v.tag = tag; v.mask = mask; v.full = full; v.cnt = cnt;
    v.cv = cv; v.cm = cm; v.sv = sv; v.sm = sm; v.rcp = rcp;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [3:0] m_vld();
    logic [3:0] m = '0;
    foreach (ord[k]) m[ord[k]] = 1'b1;
    return m;
  endfunction

  task automatic drive(input vec_t v);
    bif.alloc_valid     = v.av;
    bif.alloc_cp        = v.cp;
    bif.resolve_valid   = v.rv;
    bif.resolve_tag     = v.rt;
    bif.resolve_mispred = v.rm;
  endtask

  task automatic step(input vec_t v, input bit use_tbl);
    logic [3:0]  mv, e_tag, e_cm, e_sm;
    logic [63:0] e_rcp;
    bit          e_ok, hit, e_cv, e_sv;
    int          ridx, p, aidx;
    vec_t        x;
    @(negedge clock);
    drive(v);
    #1;
    mv   = m_vld();
    ridx = -1;
    for (int k = 0; k < 4; k++) if (v.rt[k]) ridx = k;
    hit   = v.rv && (ridx >= 0) && mv[ridx];
    e_tag = '0;
    aidx  = -1;
    for (int k = 3; k >= 0; k--) if (!mv[k]) begin e_tag = 4'(1 << k); aidx = k; end
    e_ok = v.av && (mv != 4'hF) && !(hit && v.rm);
    chk("alloc_ok",  bif.alloc_ok,  use_tbl ? 64'(v.ok)  : 64'(e_ok));
    chk("alloc_tag", bif.alloc_tag, use_tbl ? 64'(v.tag) : 64'(e_tag));

    @(posedge clock);
    e_cv = 0; e_cm = '0; e_sv = 0; e_sm = '0; e_rcp = '0;
    if (hit) begin
      p = -1;
      for (int k = 0; k < ord.size(); k++) if (ord[k] == ridx) p = k;
      if (!v.rm) begin
        e_cv = 1; e_cm = v.rt;
        ord.delete(p);
      end else begin
        e_sv = 1; e_rcp = cpm[ridx];
        for (int k = p; k < ord.size(); k++) e_sm[ord[k]] = 1'b1;
        while (ord.size() > p) void'(ord.pop_back());
      end
    end
    if (e_ok) begin
      ord.push_back(aidx);
      cpm[aidx] = v.cp;
    end
    mv = m_vld();
    #1;
    if (use_tbl) x = v;
    else begin
      x.mask = mv; x.full = (mv == 4'hF); x.cnt = 4 - $countones(mv);
      x.cv = e_cv; x.cm = e_cm; x.sv = e_sv; x.sm = e_sm; x.rcp = e_rcp;
    end
    chk("cur_mask",     bif.cur_mask,     64'(x.mask));
    chk("bs_full",      bif.bs_full,      64'(x.full));
    chk("free_cnt",     bif.free_cnt,     64'(x.cnt));
    chk("clear_valid",  bif.clear_valid,  64'(x.cv));
    chk("clear_mask",   bif.clear_mask,   64'(x.cm));
    chk("squash_valid", bif.squash_valid, 64'(x.sv));
    chk("squash_mask",  bif.squash_mask,  64'(x.sm));
    chk("restore_cp",   bif.restore_cp,   x.rcp);
  endtask

  task automatic chk_idle(input string pfx);
    chk({pfx, "_cur_mask"},     bif.cur_mask,     64'h0);
    chk({pfx, "_bs_full"},      bif.bs_full,      64'h0);
    chk({pfx, "_free_cnt"},     bif.free_cnt,     64'd4);
    chk({pfx, "_clear_valid"},  bif.clear_valid,  64'h0);
    chk({pfx, "_clear_mask"},   bif.clear_mask,   64'h0);
    chk({pfx, "_squash_valid"}, bif.squash_valid, 64'h0);
    chk({pfx, "_squash_mask"},  bif.squash_mask,  64'h0);
    chk({pfx, "_restore_cp"},   bif.restore_cp,   64'h0);
  endtask

  initial begin
    vec_t v;
    reset = 1'b1;
    v = mk(0, 0, 0, 4'b0000, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    drive(v);
    #3;
    chk_idle("reset");
    @(negedge clock);
    reset = 1'b0;

    //          av cp rv rt       rm ok tag      mask     fu cnt cv cm      sv sm       rcp
    tbl.push_back(mk(0, 0, 0, 4'b0000, 0, 0, 4'b0001, 4'b0000, 0, 4, 0, 4'b0000, 0, 4'b0000, 0));
    tbl.push_back(mk(1, 1, 0, 4'b0000, 0, 1, 4'b0001, 4'b0001, 0, 3, 0, 4'b0000, 0, 4'b0000, 0));
    tbl.push_back(mk(1, 2, 0, 4'b0000, 0, 1, 4'b0010, 4'b0011, 0, 2, 0, 4'b0000, 0, 4'b0000, 0));
    tbl.push_back(mk(1, 3, 0, 4'b0000, 0, 1, 4'b0100, 4'b0111, 0, 1, 0, 4'b0000, 0, 4'b0000, 0));
    tbl.push_back(mk(1, 4, 0, 4'b0000, 0, 1, 4'b1000, 4'b1111, 1, 0, 0, 4'b0000, 0, 4'b0000, 0));
    tbl.push_back(mk(1, 5, 0, 4'b0000, 0, 0, 4'b0000, 4'b1111, 1, 0, 0, 4'b0000, 0, 4'b0000, 0));
    tbl.push_back(mk(0, 0, 1, 4'b0010, 0, 0, 4'b0000, 4'b1101, 0, 1, 1, 4'b0010, 0, 4'b0000, 0));
    tbl.push_back(mk(1, 6, 0, 4'b0000, 0, 1, 4'b0010, 4'b1111, 1, 0, 0, 4'b0000, 0, 4'b0000, 0));
    tbl.push_back(mk(0, 0, 1, 4'b0010, 1, 0, 4'b0000, 4'b1101, 0, 1, 0, 4'b0000, 1, 4'b0010, 6));
    tbl.push_back(mk(1, 7, 1, 4'b0001, 1, 0, 4'b0010, 4'b0000, 0, 4, 0, 4'b0000, 1, 4'b1101, 1));
    tbl.push_back(mk(1, 1, 0, 4'b0000, 0, 1, 4'b0001, 4'b0001, 0, 3, 0, 4'b0000, 0, 4'b0000, 0));
    tbl.push_back(mk(1, 2, 0, 4'b0000, 0, 1, 4'b0010, 4'b0011, 0, 2, 0, 4'b0000, 0, 4'b0000, 0));
    tbl.push_back(mk(1, 3, 0, 4'b0000, 0, 1, 4'b0100, 4'b0111, 0, 1, 0, 4'b0000, 0, 4'b0000, 0));
    tbl.push_back(mk(1, 4, 0, 4'b0000, 0, 1, 4'b1000, 4'b1111, 1, 0, 0, 4'b0000, 0, 4'b0000, 0));
    tbl.push_back(mk(0, 0, 1, 4'b0010, 1, 0, 4'b0000, 4'b0001, 0, 3, 0, 4'b0000, 1, 4'b1110, 2));
    tbl.push_back(mk(1, 8, 0, 4'b0000, 0, 1, 4'b0010, 4'b0011, 0, 2, 0, 4'b0000, 0, 4'b0000, 0));
    tbl.push_back(mk(1, 9, 1, 4'b0001, 0, 1, 4'b0100, 4'b0110, 0, 2, 1, 4'b0001, 0, 4'b0000, 0));
    tbl.push_back(mk(0, 0, 1, 4'b0010, 1, 0, 4'b0001, 4'b0000, 0, 4, 0, 4'b0000, 1, 4'b0110, 8));
    tbl.push_back(mk(0, 0, 1, 4'b0001, 1, 0, 4'b0001, 4'b0000, 0, 4, 0, 4'b0000, 0, 4'b0000, 0));
    tbl.push_back(mk(0, 0, 0, 4'b0000, 0, 0, 4'b0001, 4'b0000, 0, 4, 0, 4'b0000, 0, 4'b0000, 0));
    foreach (tbl[i]) step(tbl[i], 1'b1);

    // Async reset lands between edges while a mispredict is being presented.
    step(mk(1, 64'hA1, 0, 4'b0000, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0), 1'b0);
    step(mk(1, 64'hA2, 0, 4'b0000, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0), 1'b0);
    @(negedge clock);
    drive(mk(0, 0, 1, 4'b0001, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    #2;
    reset = 1'b1;
    #1;
    chk_idle("midreset");
    ord.delete();
    for (int k = 0; k < 4; k++) cpm[k] = '0;
    @(posedge clock);
    #1;
    chk_idle("midreset_edge");
    @(negedge clock);
    reset = 1'b0;
    drive(mk(0, 0, 0, 4'b0000, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));

    for (int n = 0; n < 400; n++) begin
      v.av = ($urandom_range(0, 2) != 0);
      v.cp = {$urandom, $urandom};
      v.rv = ($urandom_range(0, 1) != 0);
      v.rt = 4'(1 << $urandom_range(0, 3));
      v.rm = ($urandom_range(0, 3) == 0);
      step(v, 1'b0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
